// File: rtl/imem_loader.sv
// Writable instruction store with a host-driven program loader.
// Holds the CPU until the image is complete and pads the tail with a self-jump.
module imem_loader #(
    parameter int         DEPTH = 32,
    parameter logic [7:0] PAD   = 8'hC2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cpu_hold,
    output logic       load_done,
    output logic [7:0] load_count,
    output logic       error
);

    localparam int AW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FULL = AW'(DEPTH);
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        FILL,
        DONE,
        ERR
    } state_t;

    state_t state, nextState;

    logic [AW-1:0] ptr;
    logic [AW-1:0] lenReg;
    logic [7:0]    loadCount;
    logic [7:0]    mem [DEPTH];
    logic          xfer;
    logic          we;
    logic [7:0]    wData;

    assign in_ready   = (state == LEN) || (state == DATA);
    assign xfer       = in_valid && in_ready;
    assign load_count = loadCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        cpu_hold  = 1'b1;
        load_done = 1'b0;
        error     = 1'b0;
        we        = 1'b0;
        wData     = in_data;
        unique case (state)
            IDLE: begin
                cpu_hold = 1'b0;
                if (load_start) nextState = LEN;
            end
            LEN: begin
                if (xfer) begin
                    if (in_data == 8'd0 || in_data > DEPTH8) nextState = ERR;
                    else                                     nextState = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    we = 1'b1;
                    if (ptr == lenReg - 1'b1)
                        nextState = (lenReg < FULL) ? FILL : DONE;
                end
            end
            FILL: begin
                we    = 1'b1;
                wData = PAD;
                if (ptr == LAST) nextState = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                nextState = IDLE;
            end
            ERR: begin
                error = 1'b1;
                if (load_start) nextState = LEN;
            end
            default: nextState = IDLE;
        endcase
    end

    // Reset restores the pad image so an aborted load leaves nothing behind
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            lenReg    <= '0;
            loadCount <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= PAD;
        end else begin
            if (we) begin
                mem[ptr[IW-1:0]] <= wData;
                ptr              <= ptr + 1'b1;
            end
            if (state == LEN && xfer) begin
                lenReg <= in_data[AW-1:0];
                ptr    <= '0;
            end
            if (nextState == LEN && state != LEN) loadCount <= '0;
            if (state == DATA && xfer) loadCount <= loadCount + 8'd1;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (cpu_hold)              rd_data = PAD;
        else if (rd_addr < DEPTH8) rd_data = mem[rd_addr[IW-1:0]];
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle-accurate load sequences
// plus table-driven readback of the instruction image.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       cpu_hold;
    logic       load_done;
    logic [7:0] load_count;
    logic       error;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_count(load_count),
        .error     (error)
    );

    localparam logic [7:0] PAD = 8'hC2;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rdVec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] srcBytes [32];
    logic [7:0] expImg   [32];
    rdVec_t     vecs     [34];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic setImage(input int len);
        for (int i = 0; i < 32; i++) expImg[i] = (i < len) ? srcBytes[i] : PAD;
    endtask

    task automatic checkImage(input string tag);
        for (int i = 0; i < 32; i++) vecs[i] = '{8'(i), expImg[i]};
        vecs[32] = '{8'd40, 8'h00};
        vecs[33] = '{8'hFF, 8'h00};
        for (int i = 0; i < 34; i++) begin
            rd_addr = vecs[i].addr;
            #1;
            check($sformatf("%s rd[%0d]", tag, vecs[i].addr), rd_data, vecs[i].exp);
        end
    endtask

    // Entered and left at a negedge; returns at the negedge of the done/error cycle.
    task automatic runLoad(input int len, input int nData, input int gap,
                           input int poke, output int doneCyc, output int rdyCnt,
                           output int fillCnt, output int lastRdy);
        int c, idx, wait_, total;
        bit sent;
        doneCyc = -1; rdyCnt = 0; fillCnt = 0; lastRdy = -1;
        idx = 0; wait_ = 0; total = 1 + nData;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        c = 1;
        while (c < 300) begin
            if (c == 1) begin
                check("len entry hold", cpu_hold, 1'b1);
                check("len entry err", error, 1'b0);
            end
            if (in_ready) begin rdyCnt++; lastRdy = c; end
            if (cpu_hold && !in_ready && !load_done && !error) fillCnt++;
            if (load_done) doneCyc = c;
            if (load_done || error) break;
            load_start = (c == poke);
            if (idx < total && wait_ == 0) begin
                in_valid = 1'b1;
                in_data  = (idx == 0) ? 8'(len) : srcBytes[idx-1];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                if (wait_ > 0) wait_--;
            end
            sent = in_valid && in_ready;
            @(negedge clk);
            if (sent) begin idx++; wait_ = gap; end
            c++;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic afterDone(input string tag, input logic [7:0] cnt);
        rd_addr = 8'd0;
        #1;
        check({tag, " masked"}, rd_data, PAD);
        check({tag, " err"}, error, 1'b0);
        @(negedge clk);
        check({tag, " hold low"}, cpu_hold, 1'b0);
        check({tag, " done low"}, load_done, 1'b0);
        check({tag, " count"}, load_count, cnt);
        checkImage(tag);
    endtask

    int dc, rc, fc, lr;
    logic [7:0] first5 [5];

    initial begin
        first5 = '{8'h45, 8'h59, 8'h1B, 8'h8C, 8'hC0};
        reset = 1'b1; load_start = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; rd_addr = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst ready", in_ready, 1'b0);
        check("rst hold", cpu_hold, 1'b0);
        check("rst done", load_done, 1'b0);
        check("rst err", error, 1'b0);
        check("rst count", load_count, 8'd0);
        setImage(0);
        checkImage("rst");

        // Continuous 5-byte load
        for (int i = 0; i < 5; i++) srcBytes[i] = first5[i];
        runLoad(5, 5, 0, -1, dc, rc, fc, lr);
        check("l5 done cyc", dc, 34);
        check("l5 rdy cnt", rc, 6);
        check("l5 rdy last", lr, 6);
        check("l5 fill cnt", fc, 27);
        setImage(5);
        afterDone("l5", 8'd5);

        // Same load, 3 idle cycles between every byte
        runLoad(5, 5, 3, -1, dc, rc, fc, lr);
        check("gap done cyc", dc, 49);
        check("gap rdy last", lr, 21);
        check("gap fill cnt", fc, 27);
        afterDone("gap", 8'd5);

        // Full-depth load, no fill phase
        for (int i = 0; i < 32; i++) srcBytes[i] = 8'(i);
        runLoad(32, 32, 0, -1, dc, rc, fc, lr);
        check("l32 done cyc", dc, 34);
        check("l32 rdy cnt", rc, 33);
        check("l32 fill cnt", fc, 0);
        setImage(32);
        afterDone("l32", 8'd32);

        // Bad lengths 0 and 33
        runLoad(0, 0, 0, -1, dc, rc, fc, lr);
        check("len0 no done", dc, -1);
        check("len0 err", error, 1'b1);
        check("len0 hold", cpu_hold, 1'b1);
        check("len0 count", load_count, 8'd0);
        in_valid = 1'b1; in_data = 8'h07;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("len0 sticky", error, 1'b1);
        check("len0 rdy", in_ready, 1'b0);
        check("len0 still hold", cpu_hold, 1'b1);

        runLoad(33, 0, 0, -1, dc, rc, fc, lr);
        check("len33 no done", dc, -1);
        check("len33 rdy cnt", rc, 1);
        check("len33 err", error, 1'b1);
        check("len33 hold", cpu_hold, 1'b1);

        // Recovery with a 1-byte load
        srcBytes[0] = 8'h9D;
        runLoad(1, 1, 0, -1, dc, rc, fc, lr);
        check("rec done cyc", dc, 34);
        check("rec fill cnt", fc, 31);
        setImage(1);
        afterDone("rec", 8'd1);

        // Reset in the middle of DATA after 3 bytes
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        in_valid = 1'b1; in_data = 8'd5;
        @(negedge clk);
        in_data = 8'hAA;
        @(negedge clk);
        in_data = 8'hBB;
        @(negedge clk);
        in_data = 8'hCC;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid count", load_count, 8'd3);
        check("mid hold", cpu_hold, 1'b1);
        reset = 1'b1;
        #1;
        check("arst hold", cpu_hold, 1'b0);
        check("arst ready", in_ready, 1'b0);
        check("arst count", load_count, 8'd0);
        check("arst err", error, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        setImage(0);
        checkImage("arst");

        // load_start during DATA must be ignored
        for (int i = 0; i < 5; i++) srcBytes[i] = first5[i];
        runLoad(5, 5, 0, 4, dc, rc, fc, lr);
        check("poke done cyc", dc, 34);
        check("poke fill cnt", fc, 27);
        setImage(5);
        afterDone("poke", 8'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
